dpb_fifo_ctrl: RTL and testbench



---
 rtl/dpb_pkg.sv | 14 +
 rtl/dpb_fifo_ptr.sv | 24 ++
 rtl/dpb_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_dpb_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpb_pkg.sv
// rtl/dpb_pkg.sv - DPB port geometry shared by the FIFO controller files
package dpb_pkg;

   localparam int D_PORT_WIDTH  = 16;
   localparam int AD_PORT_WIDTH = 14;

   typedef logic [AD_PORT_WIDTH-1:0] dpb_addr_t;

   // Number of low address bits that select a bit within a 16-bit DPB word
   function automatic int bit_addr_len(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/dpb_fifo_ptr.sv
// rtl/dpb_fifo_ptr.sv - wrapping DPB word pointer with increment enable and sync clear
module dpb_fifo_ptr
   import dpb_pkg::*;
#(
   parameter int WIDTH = 10
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dpb_fifo_ctrl.sv
// rtl/dpb_fifo_ctrl.sv - show-ahead FIFO controller over one DPB, DOB used as head register
// Optional DPB_FIFO_STATS_EN adds PEAK_COUNT and sticky OVF_ATTEMPT.
module dpb_fifo_ctrl
   import dpb_pkg::*;
#(
   parameter int          DATA_WIDTH      = 16,
   parameter logic [2:0]  BLK_SEL         = 3'b000,
   parameter int          ALMOST_FULL_LVL = 1000,
   localparam int         BIT_ADDR_LENGTH = bit_addr_len(DATA_WIDTH),
   localparam int         ADDR_WIDTH      = AD_PORT_WIDTH - BIT_ADDR_LENGTH,
   localparam int         DEPTH           = 2**ADDR_WIDTH,
   localparam int         CNT_W           = ADDR_WIDTH + 1
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    FLUSH,
   input  logic                    WR_VALID,
   output logic                    WR_READY,
   input  logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic                    RD_VALID,
   input  logic                    RD_READY,
   output logic [DATA_WIDTH-1:0]   RD_DATA,
   output logic [CNT_W-1:0]        COUNT,
   output logic                    ALMOST_FULL,
`ifdef DPB_FIFO_STATS_EN
   output logic [CNT_W-1:0]        PEAK_COUNT,
   output logic                    OVF_ATTEMPT,
`endif
   output logic                    CEA,
   output logic                    WREA,
   output dpb_addr_t               ADA,
   output logic [D_PORT_WIDTH-1:0] DIA,
   output logic                    CEB,
   output logic                    WREB,
   output dpb_addr_t               ADB,
   output logic [D_PORT_WIDTH-1:0] DIB,
   output logic                    OCEA,
   output logic                    OCEB,
   output logic                    RESETA,
   output logic                    RESETB,
   output logic [2:0]              BLKSELA,
   output logic [2:0]              BLKSELB,
   input  logic [D_PORT_WIDTH-1:0] DOB
);

   if (!(DATA_WIDTH == 1 || DATA_WIDTH == 2 || DATA_WIDTH == 4 ||
         DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_width
      $fatal(1, "dpb_fifo_ctrl: DATA_WIDTH must be 1, 2, 4, 8 or 16");
   end

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [CNT_W-1:0]      mem_cnt;
   logic                  head_vld;
   logic                  wr;
   logic                  rd_issue;

   // Readiness looks only at registered RAM occupancy, so a full RAM never
   // lets port A write the address port B is about to read.
   assign WR_READY = !FLUSH && (mem_cnt < CNT_W'(DEPTH));
   assign wr       = WR_VALID && WR_READY;
   assign rd_issue = !FLUSH && (mem_cnt != '0) && (!head_vld || RD_READY);

   dpb_fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wptr (
      .CLK    (CLK),
      .RESETN (RESETN),
      .clr    (FLUSH),
      .inc    (wr),
      .ptr    (wptr)
   );

   dpb_fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rptr (
      .CLK    (CLK),
      .RESETN (RESETN),
      .clr    (FLUSH),
      .inc    (rd_issue),
      .ptr    (rptr)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         mem_cnt  <= '0;
         head_vld <= 1'b0;
      end else if (FLUSH) begin
         mem_cnt  <= '0;
         head_vld <= 1'b0;
      end else begin
         case ({wr, rd_issue})
            2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
            2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
            default: mem_cnt <= mem_cnt;
         endcase
         if (rd_issue) begin
            head_vld <= 1'b1;
         end else if (RD_READY) begin
            head_vld <= 1'b0;
         end
      end
   end

   // DOB holds its value while CEB is low, so it doubles as the head register
   assign RD_VALID    = head_vld;
   assign RD_DATA     = DOB[DATA_WIDTH-1:0];
   assign COUNT       = mem_cnt + CNT_W'(head_vld);
   assign ALMOST_FULL = int'(COUNT) >= ALMOST_FULL_LVL;

   assign CEA     = wr;
   assign WREA    = wr;
   assign ADA     = dpb_addr_t'(wptr) << BIT_ADDR_LENGTH;
   assign DIA     = D_PORT_WIDTH'(WR_DATA);
   assign CEB     = rd_issue;
   assign WREB    = 1'b0;
   assign ADB     = dpb_addr_t'(rptr) << BIT_ADDR_LENGTH;
   assign DIB     = '0;
   assign OCEA    = 1'b1;
   assign OCEB    = 1'b1;
   assign RESETA  = 1'b0;
   assign RESETB  = 1'b0;
   assign BLKSELA = BLK_SEL;
   assign BLKSELB = BLK_SEL;

`ifdef DPB_FIFO_STATS_EN
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         PEAK_COUNT  <= '0;
         OVF_ATTEMPT <= 1'b0;
      end else if (FLUSH) begin
         PEAK_COUNT  <= '0;
         OVF_ATTEMPT <= 1'b0;
      end else begin
         if (COUNT > PEAK_COUNT) begin
            PEAK_COUNT <= COUNT;
         end
         if (WR_VALID && !WR_READY) begin
            OVF_ATTEMPT <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dpb_fifo_ctrl.sv
// tb/tb_dpb_fifo_ctrl.sv - self-checking bench for dpb_fifo_ctrl with a behavioural DPB
module tb_dpb_fifo_ctrl;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic        FLUSH = 1'b0;
   logic        WR_VALID = 1'b0;
   logic        WR_READY;
   logic [15:0] WR_DATA = '0;
   logic        RD_VALID;
   logic        RD_READY = 1'b0;
   logic [15:0] RD_DATA;
   logic [10:0] COUNT;
   logic        ALMOST_FULL;
   logic        CEA, WREA, CEB, WREB, OCEA, OCEB, RESETA, RESETB;
   logic [13:0] ADA, ADB;
   logic [15:0] DIA, DIB;
   logic [2:0]  BLKSELA, BLKSELB;
   logic [15:0] DOB = '0;

   logic [15:0] mem [0:1023];

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   dpb_fifo_ctrl #(.DATA_WIDTH(16), .BLK_SEL(3'b000), .ALMOST_FULL_LVL(1000)) dut (
      .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
      .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
      .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL),
      .CEA(CEA), .WREA(WREA), .ADA(ADA), .DIA(DIA),
      .CEB(CEB), .WREB(WREB), .ADB(ADB), .DIB(DIB),
      .OCEA(OCEA), .OCEB(OCEB), .RESETA(RESETA), .RESETB(RESETB),
      .BLKSELA(BLKSELA), .BLKSELB(BLKSELB), .DOB(DOB)
   );

   // DPB model: 1024 x 16 words, registered port-B output
   always @(posedge CLK) begin
      if (CEA && WREA) mem[ADA[13:4]] <= DIA;
      if (CEB && !WREB && OCEB) DOB <= mem[ADB[13:4]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drain_to(input int target);
      int n = 0;
      @(posedge CLK); #1;
      while (32'(COUNT) != target && n < 2000) begin
         WR_VALID = 1'b0;
         RD_READY = 1'b1;
         @(posedge CLK); #1;
         n++;
      end
      RD_READY = 1'b0;
      chk("drain_to_count", 32'(COUNT), target);
   endtask

   typedef struct packed {
      logic        wv;
      logic [15:0] wd;
      logic        rr;
      logic        fl;
      logic        e_wrdy;
      logic        e_rv;
      logic        chk_d;
      logic [15:0] e_d;
      logic [10:0] e_cnt;
      logic        e_cea;
      logic        e_ceb;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int sent, rcvd, written;
      logic full_seen;

      tbl[0] = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 11'd1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 11'd1, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 11'd2, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 11'd2, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 11'd1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 11'd0, 1'b0, 1'b0};

      // Reset state and tie-offs
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_wr_ready", 32'(WR_READY), 1);
      chk("rst_rd_valid", 32'(RD_VALID), 0);
      chk("rst_count", 32'(COUNT), 0);
      chk("rst_almost_full", 32'(ALMOST_FULL), 0);
      chk("rst_cea_wrea_ceb", 32'({CEA, WREA, CEB}), 0);
      chk("rst_ada_adb", 32'({ADA, ADB}), 0);
      chk("tie_wreb_dib", 32'({WREB, DIB}), 0);
      chk("tie_oce_reset", 32'({OCEA, OCEB, RESETA, RESETB}), 32'b1100);
      chk("tie_blksel", 32'({BLKSELA, BLKSELB}), 0);
      RESETN = 1'b1;

      // Table-driven: first-word fall-through and stall behaviour
      for (int i = 0; i < 9; i++) begin
         @(posedge CLK); #1;
         WR_VALID = tbl[i].wv;
         WR_DATA  = tbl[i].wd;
         RD_READY = tbl[i].rr;
         FLUSH    = tbl[i].fl;
         @(negedge CLK);
         chk($sformatf("vec%0d_wr_ready", i), 32'(WR_READY), 32'(tbl[i].e_wrdy));
         chk($sformatf("vec%0d_rd_valid", i), 32'(RD_VALID), 32'(tbl[i].e_rv));
         if (tbl[i].chk_d)
            chk($sformatf("vec%0d_rd_data", i), 32'(RD_DATA), 32'(tbl[i].e_d));
         chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d_cea", i), 32'(CEA), 32'(tbl[i].e_cea));
         chk($sformatf("vec%0d_ceb", i), 32'(CEB), 32'(tbl[i].e_ceb));
      end

      // Streaming 0..1999 with random back-pressure
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 20000 && rcvd < 2000; cyc++) begin
         @(posedge CLK); #1;
         WR_VALID = (sent < 2000);
         WR_DATA  = sent[15:0];
         RD_READY = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (WR_VALID && WR_READY) sent++;
         if (RD_VALID && RD_READY) begin
            chk("stream_data", 32'(RD_DATA), 32'(rcvd[15:0]));
            rcvd++;
         end
      end
      chk("stream_sent", sent, 2000);
      chk("stream_rcvd", rcvd, 2000);

      // Fill with consumer stalled
      written = 0;
      full_seen = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         @(posedge CLK); #1;
         WR_VALID = 1'b1;
         WR_DATA  = 16'h4000 + written[15:0];
         RD_READY = 1'b0;
         @(negedge CLK);
         chk("fill_count", 32'(COUNT), written);
         chk("fill_almost_full", 32'(ALMOST_FULL), 32'(written >= 1000));
         if (!WR_READY) begin
            full_seen = 1'b1;
            chk("full_cea", 32'(CEA), 0);
            break;
         end
         written++;
      end
      chk("full_seen", 32'(full_seen), 1);
      chk("full_written", written, 1025);
      chk("full_count", 32'(COUNT), 1025);

      // One read handshake from full frees RAM space on the next cycle
      @(posedge CLK); #1;
      WR_VALID = 1'b0;
      RD_READY = 1'b1;
      @(negedge CLK);
      chk("full_rd_valid", 32'(RD_VALID), 1);
      chk("full_head_data", 32'(RD_DATA), 32'h4000);
      chk("full_wr_ready_hs", 32'(WR_READY), 0);
      chk("full_ceb", 32'(CEB), 1);
      @(posedge CLK); #1;
      RD_READY = 1'b0;
      @(negedge CLK);
      chk("after_rd_wr_ready", 32'(WR_READY), 1);
      chk("after_rd_count", 32'(COUNT), 1024);
      chk("after_rd_head", 32'(RD_DATA), 32'h4001);

      // Simultaneous write and read keep the count steady
      drain_to(500);
      for (int i = 0; i < 3; i++) begin
         WR_VALID = 1'b1;
         WR_DATA  = 16'(16'h5000 + i);
         RD_READY = 1'b1;
         @(negedge CLK);
         chk("wr_rd_count", 32'(COUNT), 500);
         chk("wr_rd_cea_ceb", 32'({CEA, CEB}), 32'b11);
         @(posedge CLK); #1;
      end
      WR_VALID = 1'b0;
      RD_READY = 1'b0;
      chk("wr_rd_after", 32'(COUNT), 500);

      // Flush at 300, then a fresh word passes through
      drain_to(300);
      FLUSH    = 1'b1;
      WR_VALID = 1'b1;
      WR_DATA  = 16'hDEAD;
      @(negedge CLK);
      chk("flush_wr_ready", 32'(WR_READY), 0);
      chk("flush_cea_ceb", 32'({CEA, CEB}), 0);
      @(posedge CLK); #1;
      FLUSH    = 1'b0;
      WR_VALID = 1'b0;
      chk("flush_count", 32'(COUNT), 0);
      chk("flush_rd_valid", 32'(RD_VALID), 0);
      WR_VALID = 1'b1;
      WR_DATA  = 16'h1234;
      RD_READY = 1'b1;
      @(negedge CLK);
      chk("post_flush_cea", 32'(CEA), 1);
      @(posedge CLK); #1;
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("post_flush_ceb", 32'(CEB), 1);
      chk("post_flush_rv1", 32'(RD_VALID), 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("post_flush_rv2", 32'(RD_VALID), 1);
      chk("post_flush_data", 32'(RD_DATA), 32'h1234);

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         WR_VALID = 1'b1;
         WR_DATA  = 16'(16'h7001 + i);
         RD_READY = 1'b0;
      end
      @(posedge CLK); #1;
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("pre_rst_rd_valid", 32'(RD_VALID), 1);
      chk("pre_rst_count", 32'(COUNT), 3);
      #2;
      RESETN = 1'b0;
      #1;
      chk("async_rst_rd_valid", 32'(RD_VALID), 0);
      chk("async_rst_count", 32'(COUNT), 0);
      chk("async_rst_wr_ready", 32'(WR_READY), 1);
      @(posedge CLK); #3;
      RESETN   = 1'b1;
      WR_VALID = 1'b1;
      WR_DATA  = 16'hBEEF;
      RD_READY = 1'b1;
      @(negedge CLK);
      chk("resume_count", 32'(COUNT), 0);
      chk("resume_cea", 32'(CEA), 1);
      @(posedge CLK); #1;
      WR_VALID = 1'b0;
      @(negedge CLK);
      chk("resume_ceb", 32'(CEB), 1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("resume_rd_valid", 32'(RD_VALID), 1);
      chk("resume_data", 32'(RD_DATA), 32'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
